// File: rtl/int_ctl_n_pkg.sv
// int_ctl_n_pkg: register map and channel mode encodings shared by the interrupt controller.
package int_ctl_n_pkg;
  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_VEC  = 2'd3
  } reg_e;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
endpackage

// File: rtl/int_ctl_n_if.sv
// int_ctl_n_if: request lines, register bus and ISM acknowledge bundle of the interrupt controller.
interface int_ctl_n_if #(
  parameter int NCHAN = 8
) ();
  logic [NCHAN-1:0] nirqn;
  logic             sel;
  logic             rd;
  logic             wr;
  logic [1:0]       addr;
  logic [15:0]      wdata;
  logic [15:0]      rdata;
  logic             iack;
  logic [7:0]       vector;
  logic             nirq;
  logic             spurious;
  modport master (
    output nirqn, sel, rd, wr, addr, wdata, iack,
    input  rdata, vector, nirq, spurious
  );
  modport slave (
    input  nirqn, sel, rd, wr, addr, wdata, iack,
    output rdata, vector, nirq, spurious
  );
endinterface

// File: rtl/int_ctl_n_prio_enc.sv
// int_ctl_n_prio_enc: index of the lowest set request bit plus a valid flag.
module int_ctl_n_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = W'(i);
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/int_ctl_n.sv
// int_ctl_n: vectored interrupt controller with per-channel mask, edge/level mode, nesting and EOI.
module int_ctl_n
  import int_ctl_n_pkg::*;
#(
  parameter int         NCHAN       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] VEC_BASE    = 8'h00
) (
  input logic        clk4,
  input logic        reset,
  int_ctl_n_if.slave bus
);
  localparam int W = $clog2(NCHAN + 1);
  logic [SYNC_STAGES-1:0][NCHAN-1:0] r_sync;
  logic [NCHAN-1:0] r_s_d, r_pend, r_mask, r_mode, r_isr;
  logic [W-1:0]     r_best;
  logic             r_nirq, r_spur;
  logic [7:0]       r_vector;
  logic [15:0]      r_rdata;
  logic [NCHAN-1:0] w_s, w_rise, w_edge_ch, w_wdata, w_w1c, w_ack_oh, w_eoi_oh;
  logic [NCHAN-1:0] w_pend_nxt, w_mask_nxt, w_mode_nxt, w_isr_nxt, w_elig_nxt;
  logic [W-1:0]     w_best_idx, w_isr_idx;
  logic             w_best_v, w_isr_v, w_ack, w_wr, w_unused;
  assign w_unused   = ^bus.wdata;
  assign w_s        = ~r_sync[SYNC_STAGES-1];
  assign w_rise     = w_s & ~r_s_d;
  assign w_edge_ch  = (MODE_EDGE != MODE_LEVEL) ? r_mode : ~r_mode;
  assign w_wr       = bus.sel & bus.wr;
  assign w_wdata    = bus.wdata[NCHAN-1:0];
  assign w_w1c      = (w_wr && bus.addr == REG_PEND) ? w_wdata : '0;
  // r_best/r_nirq describe the current state, so an ack can use them directly
  assign w_ack      = bus.iack & ~r_nirq;
  assign w_ack_oh   = w_ack ? (NCHAN'(1) << r_best) : '0;
  // EOI retires the highest-priority in-service bit that existed before this cycle's ack
  assign w_eoi_oh   = (w_wr && bus.addr == REG_VEC) ? (r_isr & (~r_isr + NCHAN'(1))) : '0;
  assign w_pend_nxt = (w_edge_ch & ((r_pend & ~w_w1c & ~w_ack_oh) | w_rise)) | (~w_edge_ch & w_s);
  assign w_mask_nxt = (w_wr && bus.addr == REG_MASK) ? w_wdata : r_mask;
  assign w_mode_nxt = (w_wr && bus.addr == REG_MODE) ? w_wdata : r_mode;
  assign w_isr_nxt  = (r_isr | w_ack_oh) & ~w_eoi_oh;
  assign w_elig_nxt = w_pend_nxt & w_mask_nxt & ~w_isr_nxt;
  int_ctl_n_prio_enc #(.N(NCHAN), .W(W)) u_elig_enc (
    .i_req  (w_elig_nxt),
    .o_idx  (w_best_idx),
    .o_valid(w_best_v)
  );
  int_ctl_n_prio_enc #(.N(NCHAN), .W(W)) u_isr_enc (
    .i_req  (w_isr_nxt),
    .o_idx  (w_isr_idx),
    .o_valid(w_isr_v)
  );
  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      r_sync   <= '1;
      r_s_d    <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_mode   <= '0;
      r_isr    <= '0;
      r_best   <= '0;
      r_nirq   <= 1'b1;
      r_spur   <= 1'b0;
      r_vector <= '0;
      r_rdata  <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.nirqn};
      r_s_d    <= w_s;
      r_pend   <= w_pend_nxt;
      r_mask   <= w_mask_nxt;
      r_mode   <= w_mode_nxt;
      r_isr    <= w_isr_nxt;
      r_best   <= w_best_idx;
      r_nirq   <= ~(w_best_v && (!w_isr_v || w_best_idx < w_isr_idx));
      if (bus.iack) begin
        r_vector <= w_ack ? VEC_BASE + 8'(r_best) : VEC_BASE + 8'(NCHAN);
        r_spur   <= ~w_ack;
      end
      if (bus.sel && bus.rd)
        r_rdata <= (bus.addr == REG_PEND) ? 16'(r_pend) :
                   (bus.addr == REG_MASK) ? 16'(r_mask) :
                   (bus.addr == REG_MODE) ? 16'(r_mode) : {|r_isr, 7'b0, r_vector};
    end
  end
  assign bus.rdata    = r_rdata;
  assign bus.vector   = r_vector;
  assign bus.nirq     = r_nirq;
  assign bus.spurious = r_spur;
endmodule

// File: tb/tb_int_ctl_n.sv
// tb_int_ctl_n: directed checks of request latency, nesting, priority blocking, modes, W1C, mask, races and reset.
module tb_int_ctl_n;
  logic clk4 = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  logic [15:0] rv;
  int_ctl_n_if #(.NCHAN(8)) bus ();
  int_ctl_n #(.NCHAN(8), .SYNC_STAGES(2), .VEC_BASE(8'h00)) dut (
    .clk4 (clk4),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk4 = ~clk4;
  task automatic tick(input int n);
    repeat (n) @(posedge clk4);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wreg(input logic [1:0] a, input logic [15:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    tick(1);
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask
  task automatic rreg(input logic [1:0] a, output logic [15:0] d);
    bus.sel = 1'b1; bus.rd = 1'b1; bus.addr = a;
    tick(1);
    bus.sel = 1'b0; bus.rd = 1'b0;
    d = bus.rdata;
  endtask
  task automatic ack();
    bus.iack = 1'b1;
    tick(1);
    bus.iack = 1'b0;
  endtask
  initial begin
    bus.nirqn = '1; bus.sel = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0; bus.iack = 0;
    tick(2);
    reset = 1'b0;
    chk("rst_nirq", 16'(bus.nirq), 16'h0001);
    chk("rst_vector", 16'(bus.vector), 16'h0000);
    chk("rst_spurious", 16'(bus.spurious), 16'h0000);
    chk("rst_rdata", bus.rdata, 16'h0000);
    wreg(2'd1, 16'h00FF);
    wreg(2'd2, 16'h00FF);
    bus.nirqn[3] = 1'b0;
    tick(2);
    chk("lat_nirq_2cyc", 16'(bus.nirq), 16'h0001);
    tick(1);
    chk("lat_nirq_3cyc", 16'(bus.nirq), 16'h0000);
    ack();
    chk("ack3_vector", 16'(bus.vector), 16'h0003);
    chk("ack3_nirq", 16'(bus.nirq), 16'h0001);
    chk("ack3_spurious", 16'(bus.spurious), 16'h0000);
    rreg(2'd3, rv); chk("ack3_vecreg", rv, 16'h8003);
    rreg(2'd0, rv); chk("ack3_pend", rv, 16'h0000);
    bus.nirqn[1] = 1'b0;
    tick(3);
    chk("nest_nirq", 16'(bus.nirq), 16'h0000);
    ack();
    chk("nest_vector", 16'(bus.vector), 16'h0001);
    rreg(2'd3, rv); chk("nest_vecreg", rv, 16'h8001);
    wreg(2'd3, 16'h0000);
    rreg(2'd3, rv); chk("eoi1_vecreg", rv, 16'h8001);
    wreg(2'd3, 16'h0000);
    rreg(2'd3, rv); chk("eoi2_vecreg", rv, 16'h0001);
    chk("eoi2_nirq", 16'(bus.nirq), 16'h0001);
    bus.nirqn = '1;
    tick(4);
    bus.nirqn[1] = 1'b0;
    tick(3);
    ack();
    chk("blk_ack1_vector", 16'(bus.vector), 16'h0001);
    bus.nirqn[5] = 1'b0;
    tick(4);
    chk("blk_nirq_held", 16'(bus.nirq), 16'h0001);
    wreg(2'd3, 16'h0000);
    chk("blk_eoi_nirq", 16'(bus.nirq), 16'h0000);
    ack();
    chk("blk_ack5_vector", 16'(bus.vector), 16'h0005);
    wreg(2'd3, 16'h0000);
    bus.nirqn = '1;
    tick(4);
    wreg(2'd2, 16'h0000);
    bus.nirqn[2] = 1'b0;
    tick(3);
    chk("lvl_nirq", 16'(bus.nirq), 16'h0000);
    ack();
    chk("lvl_vector", 16'(bus.vector), 16'h0002);
    chk("lvl_ack_nirq", 16'(bus.nirq), 16'h0001);
    wreg(2'd3, 16'h0000);
    chk("lvl_eoi_nirq", 16'(bus.nirq), 16'h0000);
    bus.nirqn[2] = 1'b1;
    tick(4);
    rreg(2'd0, rv); chk("lvl_pend_release", rv, 16'h0000);
    chk("lvl_release_nirq", 16'(bus.nirq), 16'h0001);
    ack();
    chk("spur_vector", 16'(bus.vector), 16'h0008);
    chk("spur_flag", 16'(bus.spurious), 16'h0001);
    wreg(2'd3, 16'h0000);
    rreg(2'd3, rv); chk("spur_eoi_vecreg", rv, 16'h0008);
    chk("spur_eoi_nirq", 16'(bus.nirq), 16'h0001);
    wreg(2'd2, 16'h00FF);
    bus.nirqn[4] = 1'b0;
    tick(3);
    chk("w1c_nirq", 16'(bus.nirq), 16'h0000);
    rreg(2'd0, rv); chk("w1c_pend_before", rv, 16'h0010);
    wreg(2'd0, 16'h0010);
    chk("w1c_nirq_after", 16'(bus.nirq), 16'h0001);
    rreg(2'd0, rv); chk("w1c_pend_after", rv, 16'h0000);
    bus.nirqn[4] = 1'b1;
    wreg(2'd1, 16'h00BF);
    bus.nirqn[6] = 1'b0;
    tick(3);
    chk("mask_nirq_off", 16'(bus.nirq), 16'h0001);
    rreg(2'd0, rv); chk("mask_pend", rv, 16'h0040);
    wreg(2'd1, 16'h00FF);
    chk("mask_nirq_on", 16'(bus.nirq), 16'h0000);
    ack();
    chk("mask_vector", 16'(bus.vector), 16'h0006);
    wreg(2'd3, 16'h0000);
    bus.nirqn[6] = 1'b1;
    tick(3);
    bus.nirqn[0] = 1'b0;
    tick(3);
    chk("race_nirq", 16'(bus.nirq), 16'h0000);
    bus.nirqn[0] = 1'b1;
    tick(3);
    bus.nirqn[0] = 1'b0;
    tick(2);
    ack();
    chk("race_vector", 16'(bus.vector), 16'h0000);
    rreg(2'd0, rv); chk("race_pend", rv, 16'h0001);
    rreg(2'd3, rv); chk("race_vecreg", rv, 16'h8000);
    chk("race_nirq_after", 16'(bus.nirq), 16'h0001);
    wreg(2'd3, 16'h0000);
    chk("race_eoi_nirq", 16'(bus.nirq), 16'h0000);
    bus.iack = 1'b1;
    #2 reset = 1'b1;
    tick(1);
    bus.iack = 1'b0;
    chk("midrst_nirq", 16'(bus.nirq), 16'h0001);
    chk("midrst_vector", 16'(bus.vector), 16'h0000);
    chk("midrst_spurious", 16'(bus.spurious), 16'h0000);
    chk("midrst_rdata", bus.rdata, 16'h0000);
    reset = 1'b0;
    tick(1);
    rreg(2'd1, rv); chk("midrst_mask", rv, 16'h0000);
    rreg(2'd3, rv); chk("midrst_vecreg", rv, 16'h0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
